ifu_fetch_queue: RTL and testbench
==================================

// Module: ifu_fetch_queue
// PURPOSE
//  Parametrised instruction fetch queue between the IFU AXI fetch path and ID; next generation of 2-wide fixed IF/ID pipe reg.
//  Accepts FETCH_WIDTH-instruction bus beats, drops slots before start PC / after predicted-taken branch, packs survivors
//  into per-instruction circular buffer, presents up to ISSUE_WIDTH oldest instructions to ID in program order.
// PARAMETERS
//  FETCH_WIDTH  2   instructions per fetch beat (power of 2, 1..4)
//  ISSUE_WIDTH  2   instructions presented to ID per cycle (1..FETCH_WIDTH)
//  DEPTH        8   queue entries, one instruction each (power of 2, >= 2*FETCH_WIDTH)
//  ADDR_WIDTH   32  instruction address width
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 reset, asynchronous, active-high
//  flush_i          in   1                 discard all queued/incoming instructions
//  beat_valid_i     in   1                 fetch beat present
//  beat_ready_o     out  1                 queue accepts beat this cycle
//  beat_data_i      in   FETCH_WIDTH*32    slot k at bits [32k+31:32k]
//  beat_addr_i      in   ADDR_WIDTH        PC that started beat; start slot S = addr[log2(FETCH_WIDTH)+1:2]
//  beat_kill_i      in   FETCH_WIDTH       per-slot disable (slots after predicted-taken branch)
//  beat_pred_i      in   FETCH_WIDTH       per-slot predicted-taken flag
//  beat_err_i       in   1                 AXI read response error for beat
//  inst_o           out  ISSUE_WIDTH*32    queue head .. head+ISSUE_WIDTH-1
//  inst_addr_o      out  ISSUE_WIDTH*ADDR_WIDTH  per-slot PC
//  inst_pred_o      out  ISSUE_WIDTH       per-slot predicted-taken flag
//  inst_err_o       out  ISSUE_WIDTH       per-slot fetch fault (bus error or misaligned PC)
//  inst_valid_o     out  ISSUE_WIDTH       thermometer: bit k = (count > k)
//  deq_cnt_i        in   $clog2(ISSUE_WIDTH+1)  instructions ID consumes this cycle (0 = stall)
//  count_o          out  $clog2(DEPTH+1)   occupancy
// BEHAVIOUR
//  - Reset: head=tail=count=0; inst_valid_o=0, count_o=0, beat_ready_o=0, all data outputs 0.
//  - beat_ready_o registered: next = (DEPTH - count_next >= FETCH_WIDTH) && !rst; first cycle after reset = 1.
//  - Enqueue on beat_valid_i && beat_ready_o && !flush_i. Slot k kept iff k >= S && !beat_kill_i[k];
//    kept slots written at tail, tail+1, ... in ascending k; addr = {beat_addr_i[AW-1:log2(FW)+2], k[..], 2'b00}.
//  - Fault beat (beat_err_i=1 or beat_addr_i[1:0]!=0): exactly one entry, inst=32'h00000013, addr=beat_addr_i,
//    pred=0, err=1; beat_data_i, kill and pred ignored.
//  - Zero kept slots (all killed): handshake completes, nothing written.
//  - Latency: enqueued instruction visible on outputs cycle after handshake; no same-cycle bypass.
//  - Outputs read combinationally from storage at head; data of slots with inst_valid_o[k]=0 is don't-care.
//  - Dequeue: head += deq_cnt_i, clamped to count; deq_cnt_i > count is protocol violation (SVA fires).
//  - Simultaneous enq+deq: count_next = count + n_enq - n_deq; pointers wrap modulo DEPTH.
//  - Full: count > DEPTH-FETCH_WIDTH drops beat_ready_o next cycle; enqueue never overwrites unread entries.
//  - Empty: inst_valid_o=0, deq_cnt_i must be 0.
//  - flush_i: next cycle head=tail=count=0, inst_valid_o=0; same-cycle enqueue and dequeue discarded;
//    beat_ready_o=1 next cycle. Flush has priority over everything except rst.
//  - rst mid-operation: all state cleared asynchronously; partially written beats lost.
// CONFIGURATION
//  IFQ_STATS_EN defined: adds outputs stat_full_o[31:0] (cycles beat_valid_i && !beat_ready_o) and
//    stat_flush_drop_o[31:0] (sum of count at each flush_i); both saturate at 32'hFFFFFFFF, reset to 0.
//  IFQ_STATS_EN undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Reset release, beat addr=0x1000 data {B,A}, kill=0 -> next cycle valid=2'b11, insts A@0x1000, B@0x1004.
//  2 addr=0x1004 (S=1) data {B,A} -> only B@0x1004 queued, count_o=1, valid=2'b01.
//  3 kill=2'b10, pred=2'b01 at 0x2000 -> one entry 0x2000 with pred=1; count_o=1.
//  4 deq_cnt_i=0, 4 beats of 2 at DEPTH=8 -> count_o=8, beat_ready_o=0; one deq of 2 -> ready=1 next cycle.
//  5 count=5, flush_i with beat_valid_i=1 and deq_cnt_i=2 -> next cycle count_o=0, valid=0, ready=1 (stats: drop+=5).
//  6 beat_err_i=1 at 0x3008 -> single entry inst=0x00000013 addr=0x3008 err=1; addr 0x3002 -> same, err=1.
//  7 Random enq/deq 10k cycles at FETCH=4, ISSUE=2, DEPTH=16 vs scoreboard -> order, PCs, flags match; no overflow.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: packs surviving beat slots into a circular buffer, issues oldest to ID.
// Define IFQ_STATS_EN to add the stat_full_o / stat_flush_drop_o counters.
module ifu_fetch_queue #(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush_i,
   input  logic                              beat_valid_i,
   output logic                              beat_ready_o,
   input  logic [FETCH_WIDTH*32-1:0]         beat_data_i,
   input  logic [ADDR_WIDTH-1:0]             beat_addr_i,
   input  logic [FETCH_WIDTH-1:0]            beat_kill_i,
   input  logic [FETCH_WIDTH-1:0]            beat_pred_i,
   input  logic                              beat_err_i,
   output logic [ISSUE_WIDTH*32-1:0]         inst_o,
   output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] inst_addr_o,
   output logic [ISSUE_WIDTH-1:0]            inst_pred_o,
   output logic [ISSUE_WIDTH-1:0]            inst_err_o,
   output logic [ISSUE_WIDTH-1:0]            inst_valid_o,
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]  deq_cnt_i,
   output logic [$clog2(DEPTH+1)-1:0]        count_o
`ifdef IFQ_STATS_EN
   ,
   output logic [31:0]                       stat_full_o,
   output logic [31:0]                       stat_flush_drop_o
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]           mem_inst [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
   logic [DEPTH-1:0]      mem_pred;
   logic [DEPTH-1:0]      mem_err;

   logic [PW-1:0]          head, tail;
   logic [CW-1:0]          count, count_next;
   logic [CW-1:0]          kept, n_enq, n_deq;
   logic                   fault, enq;
   logic [FETCH_WIDTH-1:0] keep;
   logic [SW-1:0]          start;
   logic [PW-1:0]          widx [FETCH_WIDTH];
   logic [ADDR_WIDTH-1:0]  base;

   if (FETCH_WIDTH > 1) begin : g_start
      assign start = beat_addr_i[SW+1:2];
   end else begin : g_start1
      assign start = '0;
   end

   assign base  = beat_addr_i & ~ADDR_WIDTH'(FETCH_WIDTH*4-1);
   assign fault = beat_err_i || (beat_addr_i[1:0] != 2'b00);
   assign enq   = beat_valid_i && beat_ready_o && !flush_i;

   always_comb begin
      for (int k = 0; k < FETCH_WIDTH; k++)
         keep[k] = (SW'(k) >= start) && !beat_kill_i[k];
   end

   // Survivors are packed densely: slot k lands after all kept slots below it
   always_comb begin
      kept = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         widx[k] = tail + kept[PW-1:0];
         if (keep[k]) kept = kept + CW'(1);
      end
   end

   assign n_enq = !enq ? '0 : (fault ? CW'(1) : kept);
   assign n_deq = (CW'(deq_cnt_i) > count) ? count : CW'(deq_cnt_i);
   assign count_next = flush_i ? '0 : count + n_enq - n_deq;
   assign count_o = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         beat_ready_o <= 1'b0;
      end else begin
         count        <= count_next;
         beat_ready_o <= (CW'(DEPTH) - count_next) >= CW'(FETCH_WIDTH);
         if (flush_i) begin
            head <= '0;
            tail <= '0;
         end else begin
            head <= head + n_deq[PW-1:0];
            tail <= tail + n_enq[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         if (fault) begin
            mem_inst[tail] <= NOP;
            mem_addr[tail] <= beat_addr_i;
            mem_pred[tail] <= 1'b0;
            mem_err[tail]  <= 1'b1;
         end else begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
               if (keep[k]) begin
                  mem_inst[widx[k]] <= beat_data_i[k*32 +: 32];
                  mem_addr[widx[k]] <= base | ADDR_WIDTH'(k*4);
                  mem_pred[widx[k]] <= beat_pred_i[k];
                  mem_err[widx[k]]  <= 1'b0;
               end
            end
         end
      end
   end

   for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_out
      logic [PW-1:0] r;
      assign r = head + PW'(i);
      assign inst_valid_o[i] = count > CW'(i);
      assign inst_o[i*32 +: 32] = inst_valid_o[i] ? mem_inst[r] : '0;
      assign inst_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH] =
         inst_valid_o[i] ? mem_addr[r] : '0;
      assign inst_pred_o[i] = inst_valid_o[i] && mem_pred[r];
      assign inst_err_o[i]  = inst_valid_o[i] && mem_err[r];
   end

`ifdef IFQ_STATS_EN
   logic [32:0] drop_sum;
   assign drop_sum = {1'b0, stat_flush_drop_o} + 33'(count);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_full_o       <= '0;
         stat_flush_drop_o <= '0;
      end else begin
         if (beat_valid_i && !beat_ready_o && stat_full_o != '1)
            stat_full_o <= stat_full_o + 32'd1;
         if (flush_i)
            stat_flush_drop_o <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
   end
`endif

   a_deq_le_count: assert property (@(posedge clk) disable iff (rst)
      CW'(deq_cnt_i) <= count);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      count_next <= CW'(DEPTH));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed-vector bench for ifu_fetch_queue (FETCH=2, ISSUE=2, DEPTH=8)
// plus reset and queue-model sequences.
module tb_ifu_fetch_queue;
   logic        clk;
   logic        rst;
   logic        flush_i;
   logic        beat_valid_i;
   logic        beat_ready_o;
   logic [63:0] beat_data_i;
   logic [31:0] beat_addr_i;
   logic [1:0]  beat_kill_i;
   logic [1:0]  beat_pred_i;
   logic        beat_err_i;
   logic [63:0] inst_o;
   logic [63:0] inst_addr_o;
   logic [1:0]  inst_pred_o;
   logic [1:0]  inst_err_o;
   logic [1:0]  inst_valid_o;
   logic [1:0]  deq_cnt_i;
   logic [3:0]  count_o;

   int errors = 0;
   int checks = 0;

   ifu_fetch_queue #(
      .FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8), .ADDR_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
      .beat_data_i(beat_data_i), .beat_addr_i(beat_addr_i),
      .beat_kill_i(beat_kill_i), .beat_pred_i(beat_pred_i),
      .beat_err_i(beat_err_i), .inst_o(inst_o),
      .inst_addr_o(inst_addr_o), .inst_pred_o(inst_pred_o),
      .inst_err_o(inst_err_o), .inst_valid_o(inst_valid_o),
      .deq_cnt_i(deq_cnt_i), .count_o(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl, bv;
      logic [31:0] addr;
      logic [63:0] data;
      logic [1:0]  kill, pred;
      logic        err;
      logic [1:0]  deq;
      logic [3:0]  e_cnt;
      logic        e_rdy;
      logic [1:0]  e_val;
      logic [31:0] e_i0, e_a0, e_i1, e_a1;
      logic [1:0]  e_pred, e_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] a;
      logic        p;
      logic        e;
   } ent_t;

   vec_t vt[21];
   ent_t q[$];
   logic m_rdy;

   function automatic vec_t mk(input int fl, bv, ad, s1, s0, kl, pr,
      er, dq, cnt, rdy, vl, i0, a0, i1, a1, ep, ee);
      vec_t v;
      v.fl = 1'(fl);      v.bv = 1'(bv);
      v.addr = 32'(ad);   v.data = {32'(s1), 32'(s0)};
      v.kill = 2'(kl);    v.pred = 2'(pr);
      v.err = 1'(er);     v.deq = 2'(dq);
      v.e_cnt = 4'(cnt);  v.e_rdy = 1'(rdy);
      v.e_val = 2'(vl);
      v.e_i0 = 32'(i0);   v.e_a0 = 32'(a0);
      v.e_i1 = 32'(i1);   v.e_a1 = 32'(a1);
      v.e_pred = 2'(ep);  v.e_err = 2'(ee);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, bv, input logic [31:0] ad,
      input logic [63:0] d, input logic [1:0] kl, pr, input logic er,
      input logic [1:0] dq);
      flush_i = fl;      beat_valid_i = bv;
      beat_addr_i = ad;  beat_data_i = d;
      beat_kill_i = kl;  beat_pred_i = pr;
      beat_err_i = er;   deq_cnt_i = dq;
   endtask

   initial begin
      int mx;
      logic        r_fl, r_bv, r_er;
      logic [31:0] r_a;
      logic [63:0] r_d;
      logic [1:0]  r_kl, r_pr, r_dq;

      vt[0]  = mk(0,1,'h0000,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0);
      vt[0].bv = 1'b0;
      vt[1]  = mk(0,1,'h1000,'hB002,'hA001,0,0,0,0,
                  2,1,3,'hA001,'h1000,'hB002,'h1004,0,0);
      vt[2]  = mk(0,1,'h1004,'hC003,'hD004,0,0,0,2,
                  1,1,1,'hC003,'h1004,0,0,0,0);
      vt[3]  = mk(0,1,'h2000,'hF006,'hE005,2,1,0,1,
                  1,1,1,'hE005,'h2000,0,0,1,0);
      vt[4]  = mk(0,1,'h3008,'hDEAD,'hBEEF,0,3,1,0,
                  2,1,3,'hE005,'h2000,'h13,'h3008,1,2);
      vt[5]  = mk(0,1,'h3002,'h1111,'h2222,3,3,0,2,
                  1,1,1,'h13,'h3002,0,0,0,1);
      vt[6]  = mk(0,1,'h4000,'h1,'h2,3,0,0,0,
                  1,1,1,'h13,'h3002,0,0,0,1);
      vt[7]  = mk(0,1,'h4000,'h4441,'h4440,0,0,0,1,
                  2,1,3,'h4440,'h4000,'h4441,'h4004,0,0);
      vt[8]  = mk(0,1,'h5000,'h5551,'h5550,0,0,0,0,
                  4,1,3,'h4440,'h4000,'h4441,'h4004,0,0);
      vt[9]  = mk(0,1,'h6000,'h6661,'h6660,0,0,0,0,
                  6,1,3,'h4440,'h4000,'h4441,'h4004,0,0);
      vt[10] = mk(0,1,'h7000,'h7771,'h7770,0,0,0,0,
                  8,0,3,'h4440,'h4000,'h4441,'h4004,0,0);
      vt[11] = mk(0,1,'h8000,'h8881,'h8880,0,0,0,2,
                  6,1,3,'h5550,'h5000,'h5551,'h5004,0,0);
      vt[12] = mk(0,0,0,0,0,0,0,0,2,
                  4,1,3,'h6660,'h6000,'h6661,'h6004,0,0);
      vt[13] = mk(0,0,0,0,0,0,0,0,1,
                  3,1,3,'h6661,'h6004,'h7770,'h7000,0,0);
      vt[14] = mk(0,1,'h9000,'h9991,'h9990,0,0,0,0,
                  5,1,3,'h6661,'h6004,'h7770,'h7000,0,0);
      vt[15] = mk(1,1,'hA000,'hAAA1,'hAAA0,0,0,0,2,
                  0,1,0,0,0,0,0,0,0);
      vt[16] = mk(0,1,'hB000,'hB1,'hB0,0,2,0,0,
                  2,1,3,'hB0,'hB000,'hB1,'hB004,2,0);
      vt[17] = mk(0,1,'hC004,'hC1,'hC0,0,0,0,0,
                  3,1,3,'hB0,'hB000,'hB1,'hB004,2,0);
      vt[18] = mk(0,1,'hD000,'hD1,'hD0,0,0,0,0,
                  5,1,3,'hB0,'hB000,'hB1,'hB004,2,0);
      vt[19] = mk(0,1,'hE000,'hE1,'hE0,0,0,0,0,
                  7,0,3,'hB0,'hB000,'hB1,'hB004,2,0);
      vt[20] = mk(0,1,'hF000,'hF1,'hF0,0,0,0,1,
                  6,1,3,'hB1,'hB004,'hC1,'hC004,1,0);

      rst = 1'b1;
      drive(0, 0, '0, '0, '0, '0, 0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt", 64'(count_o), 64'd0);
      chk("rst_rdy", 64'(beat_ready_o), 64'd0);
      chk("rst_val", 64'(inst_valid_o), 64'd0);
      chk("rst_inst", inst_o, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(vt[i].fl, vt[i].bv, vt[i].addr, vt[i].data,
               vt[i].kill, vt[i].pred, vt[i].err, vt[i].deq);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_cnt", i), 64'(count_o), 64'(vt[i].e_cnt));
         chk($sformatf("v%0d_rdy", i), 64'(beat_ready_o), 64'(vt[i].e_rdy));
         chk($sformatf("v%0d_val", i), 64'(inst_valid_o), 64'(vt[i].e_val));
         if (vt[i].e_val[0]) begin
            chk($sformatf("v%0d_i0", i), 64'(inst_o[31:0]), 64'(vt[i].e_i0));
            chk($sformatf("v%0d_a0", i), 64'(inst_addr_o[31:0]),
                64'(vt[i].e_a0));
            chk($sformatf("v%0d_p0", i), 64'(inst_pred_o[0]),
                64'(vt[i].e_pred[0]));
            chk($sformatf("v%0d_e0", i), 64'(inst_err_o[0]),
                64'(vt[i].e_err[0]));
         end
         if (vt[i].e_val[1]) begin
            chk($sformatf("v%0d_i1", i), 64'(inst_o[63:32]), 64'(vt[i].e_i1));
            chk($sformatf("v%0d_a1", i), 64'(inst_addr_o[63:32]),
                64'(vt[i].e_a1));
            chk($sformatf("v%0d_p1", i), 64'(inst_pred_o[1]),
                64'(vt[i].e_pred[1]));
            chk($sformatf("v%0d_e1", i), 64'(inst_err_o[1]),
                64'(vt[i].e_err[1]));
         end
      end

      // asynchronous reset mid-cycle with 6 entries queued
      drive(0, 1, 32'h1200, 64'h1, '0, '0, 0, '0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cnt", 64'(count_o), 64'd0);
      chk("arst_val", 64'(inst_valid_o), 64'd0);
      chk("arst_rdy", 64'(beat_ready_o), 64'd0);
      #2;
      rst = 1'b0;
      drive(0, 0, '0, '0, '0, '0, 0, '0);
      @(posedge clk);
      #1;
      chk("arst_rdy_after", 64'(beat_ready_o), 64'd1);
      chk("arst_cnt_after", 64'(count_o), 64'd0);

      q.delete();
      m_rdy = 1'b1;
      for (int c = 0; c < 600; c++) begin
         r_fl = ($urandom_range(0, 31) == 0);
         r_bv = ($urandom_range(0, 3) != 0);
         r_a  = {16'h0, 16'($urandom_range(0, 'hFFFF))} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) r_a[1:0] = 2'($urandom_range(1, 3));
         r_er = ($urandom_range(0, 15) == 0);
         r_kl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         r_pr = 2'($urandom_range(0, 3));
         r_d  = {$urandom, $urandom};
         mx   = (q.size() < 2) ? q.size() : 2;
         r_dq = 2'($urandom_range(0, mx));
         drive(r_fl, r_bv, r_a, r_d, r_kl, r_pr, r_er, r_dq);
         @(posedge clk);
         if (r_bv && m_rdy && !r_fl) begin
            if (r_er || r_a[1:0] != 2'b00)
               q.push_back({32'h13, r_a, 1'b0, 1'b1});
            else
               for (int k = 0; k < 2; k++)
                  if (k >= int'(r_a[2]) && !r_kl[k])
                     q.push_back({r_d[k*32 +: 32],
                                  (r_a & ~32'h7) | 32'(k*4),
                                  r_pr[k], 1'b0});
         end
         if (r_fl) q.delete();
         else for (int k = 0; k < int'(r_dq); k++) void'(q.pop_front());
         m_rdy = (8 - q.size()) >= 2;
         #1;
         chk("rnd_cnt", 64'(count_o), 64'(q.size()));
         chk("rnd_rdy", 64'(beat_ready_o), 64'(m_rdy));
         chk("rnd_val", 64'(inst_valid_o),
             64'({q.size() > 1, q.size() > 0}));
         for (int k = 0; k < 2; k++) begin
            if (k < q.size()) begin
               chk("rnd_inst", 64'(inst_o[k*32 +: 32]), 64'(q[k].i));
               chk("rnd_addr", 64'(inst_addr_o[k*32 +: 32]), 64'(q[k].a));
               chk("rnd_pred", 64'(inst_pred_o[k]), 64'(q[k].p));
               chk("rnd_err", 64'(inst_err_o[k]), 64'(q[k].e));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
